// File: rtl/cmp_sched_pkg.sv
// cmp_sched_pkg: shared FSM state encoding and default sizing for cmp_sched
package cmp_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CMP = 2'd1, RESP = 2'd2} state_t;
  localparam int NREQ_DEF = 4;
  localparam int W_DEF = 4;
endpackage

// File: rtl/cmp_core.sv
// cmp_core: W-bit magnitude compare, two's complement when CMP_SCHED_SIGNED_EN is defined
module cmp_core #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt,
  output logic         eq,
  output logic         lt
);
  always_comb begin
`ifdef CMP_SCHED_SIGNED_EN
    gt = $signed(a) > $signed(b);
`else
    gt = a > b;
`endif
    eq = a == b;
    lt = !gt && !eq;
  end
endmodule

// File: rtl/cmp_sched.sv
// cmp_sched: round-robin scheduler sharing one comparator; CMP_SCHED_SIGNED_EN selects signed compare
module cmp_sched
  import cmp_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W = W_DEF,
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0] gnt,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IW-1:0]   rsp_id,
  output logic            rsp_gt,
  output logic            rsp_eq,
  output logic            rsp_lt,
  output logic            busy
);
  state_t state, nxt;
  logic [IW-1:0] rr_ptr, rr_nxt, win, win_hi, win_lo, id_q;
  logic hi_hit;
  logic [W-1:0] a_sel, b_sel, a_q, b_q;
  logic gt_c, eq_c, lt_c, gt_q, eq_q, lt_q;
  always_comb begin
    win_hi = '0;
    win_lo = '0;
    hi_hit = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) win_lo = IW'(i);
      if (req[i] && i >= int'(rr_ptr)) begin
        win_hi = IW'(i);
        hi_hit = 1'b1;
      end
    end
  end
  assign win = hi_hit ? win_hi : win_lo;
  assign rr_nxt = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == win) begin
        a_sel = a_in[i*W +: W];
        b_sel = b_in[i*W +: W];
      end
    end
  end
  cmp_core #(.W(W)) u_core (.a(a_q), .b(b_q), .gt(gt_c), .eq(eq_c), .lt(lt_c));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state == IDLE ? (|req ? CMP : IDLE) :
          state == CMP  ? RESP :
          (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      rsp_id <= '0;
      gt_q <= 1'b0;
      eq_q <= 1'b0;
      lt_q <= 1'b0;
    end else begin
      if (state == IDLE && |req) begin
        a_q <= a_sel;
        b_q <= b_sel;
        id_q <= win;
        rr_ptr <= rr_nxt;
      end
      if (state == CMP) begin
        gt_q <= gt_c;
        eq_q <= eq_c;
        lt_q <= lt_c;
        rsp_id <= id_q;
      end
    end
  end
  assign gnt = state == CMP ? NREQ'(1) << id_q : '0;
  assign rsp_valid = state == RESP;
  assign rsp_gt = rsp_valid & gt_q;
  assign rsp_eq = rsp_valid & eq_q;
  assign rsp_lt = rsp_valid & lt_q;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_cmp_sched.sv
// tb_cmp_sched: table-driven and scoreboarded checks of cmp_sched arbitration, latency, backpressure and reset
module tb_cmp_sched;
  localparam int N = 4;
  localparam int W = 4;
`ifdef CMP_SCHED_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N-1:0] req;
  logic [N*W-1:0] a_in, b_in;
  logic [N-1:0] gnt;
  logic rsp_valid, rsp_ready;
  logic [1:0] rsp_id;
  logic rsp_gt, rsp_eq, rsp_lt, busy;
  int checks = 0;
  int fails = 0;
  typedef struct packed {logic [1:0] id; logic gt; logic eq; logic lt;} rsp_t;
  typedef struct {logic [3:0] req; logic [3:0] a; logic [3:0] b; rsp_t exp;} vec_t;
  vec_t vecs[7];
  rsp_t sb[$];
  cmp_sched #(.NREQ(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_gt(rsp_gt), .rsp_eq(rsp_eq), .rsp_lt(rsp_lt), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic rsp_t r3(input int id, input int c);
    rsp_t r;
    r.id = 2'(id);
    r.gt = c == 0;
    r.eq = c == 1;
    r.lt = c == 2;
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [3:0] r, input logic [3:0] a, input logic [3:0] b, input int w);
    req = r;
    for (int i = 0; i < N; i++) begin
      a_in[i*W +: W] = (i == w) ? a : b;
      b_in[i*W +: W] = (i == w) ? b : a;
    end
  endtask
  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == '0 && n < 6);
  endtask
  task automatic run(input logic [3:0] r, input logic [3:0] a, input logic [3:0] b, input rsp_t e, input string tag);
    int n;
    @(negedge clk);
    drive(r, a, b, int'(e.id));
    sb.push_back(e);
    wait_gnt(n);
    chk({tag, "_gnt_lat"}, n, 1);
    chk({tag, "_gnt"}, gnt, 32'(4'b1 << e.id));
    req = '0;
    @(negedge clk);
    chk({tag, "_gnt_pulse"}, gnt, 0);
    chk({tag, "_valid"}, rsp_valid, 1);
    if (rsp_valid && sb.size() > 0) begin
      rsp_t p;
      p = sb.pop_front();
      chk({tag, "_rsp"}, {rsp_id, rsp_gt, rsp_eq, rsp_lt}, p);
    end else if (sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
    chk({tag, "_idle"}, {busy, rsp_valid}, 0);
  endtask
  initial begin
    int n, g, r, last;
    int order[5] = '{0, 1, 2, 3, 0};
    vecs[0] = '{4'b0100, 4'd9, 4'd3, r3(2, SGN ? 2 : 0)};
    vecs[1] = '{4'b0011, 4'd2, 4'd7, r3(0, 2)};
    vecs[2] = '{4'b0011, 4'd15, 4'd0, r3(1, SGN ? 2 : 0)};
    vecs[3] = '{4'b1001, 4'd7, 4'd7, r3(3, 1)};
    vecs[4] = '{4'b1000, 4'd0, 4'd15, r3(3, SGN ? 0 : 2)};
    vecs[5] = '{4'b0001, 4'd8, 4'd1, r3(0, SGN ? 2 : 0)};
    vecs[6] = '{4'b0010, 4'd15, 4'd15, r3(1, 1)};
    req = '0;
    a_in = '0;
    b_in = '0;
    rsp_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs", {gnt, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, busy}, 0);
    #9 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_quiet", {busy, gnt, rsp_valid}, 0);
    end
    for (int i = 0; i < 7; i++) run(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    drive(4'b1111, 4'd5, 4'd5, 0);
    g = 0;
    r = 0;
    last = 0;
    for (int c = 0; c < 40 && r < 5; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        chk("rr_order", gnt, 32'(4'b1 << order[g]));
        if (g > 0) chk("rr_spacing", c - last, 3);
        last = c;
        g++;
        if (g == 5) req = '0;
      end
      if (rsp_valid) begin
        chk("rr_rsp", {rsp_id, rsp_gt, rsp_eq, rsp_lt}, {2'(order[r]), 3'b010});
        r++;
      end
    end
    chk("rr_count", r, 5);
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(4'b0010, 4'd2, 4'd7, 1);
    wait_gnt(n);
    chk("bp_gnt", gnt, 4'b0010);
    req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, gnt}, {1'b1, 2'd1, 3'b001, 4'b0});
    end
    req = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {busy, rsp_valid, gnt}, 0);
    @(negedge clk);
    drive(4'b0100, 4'd9, 4'd3, 2);
    wait_gnt(n);
    chk("rst_cmp_gnt", gnt, 4'b0100);
    rst_n = 1'b0;
    #1 chk("rst_async", {gnt, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, busy}, 0);
    #1 rst_n = 1'b1;
    req = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_stale", {busy, rsp_valid}, 0);
    end
    run(4'b1010, 4'd6, 4'd4, r3(1, 0), "post_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
